// File: rtl/lzw_dict_ctrl.sv
// lzw_dict_ctrl -- LZW compression dictionary controller.
//
// Walks an input symbol stream and extends the current prefix while the
// external CAM reports that {prefix, char} is already in the dictionary.
// On a miss the current prefix is emitted as a code, the new string is
// inserted into the CAM under the next free code, and the prefix restarts
// from the missed character. The final prefix of a stream is emitted with
// out_last set.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous reset, active low
//   in_valid     input symbol valid
//   in_ready     controller accepts a symbol this cycle
//   in_char      input symbol (CHAR_W bits)
//   in_last      symbol is the final one of its stream
//   out_valid    out_code / out_last valid
//   out_ready    downstream accepts the code
//   out_code     emitted code (CODE_W bits)
//   out_last     emitted code closes the stream
//   cam_key      {prefix, char} presented to the CAM for search and write
//   cam_search   one-cycle search strobe
//   cam_hit      CAM match flag, one cycle after cam_search
//   cam_code     matching code, valid with cam_hit
//   cam_wr       one-cycle insert strobe
//   cam_wr_code  code assigned to cam_key on insert
//   clr          dictionary clear, honoured only while idle
//   dict_full    every code has been allocated

module lzw_dict_ctrl #(
  parameter int CHAR_W = 8,
  parameter int CODE_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHAR_W-1:0]        in_char,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CODE_W-1:0]        out_code,
  output logic                     out_last,
  output logic [CODE_W+CHAR_W-1:0] cam_key,
  output logic                     cam_search,
  input  logic                     cam_hit,
  input  logic [CODE_W-1:0]        cam_code,
  output logic                     cam_wr,
  output logic [CODE_W-1:0]        cam_wr_code,
  input  logic                     clr,
  output logic                     dict_full
);

  localparam int KEY_W = CODE_W + CHAR_W;

  // First allocatable code sits just above the literal symbol codes;
  // LAST_CODE is the highest code the dictionary can hold.
  localparam logic [CODE_W:0] FIRST_CODE =
    {{(CODE_W-CHAR_W){1'b0}}, 1'b1, {CHAR_W{1'b0}}};
  localparam logic [CODE_W:0] LAST_CODE = {1'b0, {CODE_W{1'b1}}};

  typedef enum logic [2:0] {
    IDLE,
    GET,
    LOOKUP,
    EMIT,
    FLUSH
  } state_t;

  state_t             state;
  state_t             state_nx;

  logic [CODE_W-1:0]  prefix;
  logic [CHAR_W-1:0]  char_q;
  logic               last_q;
  logic [CODE_W:0]    next_code;
  logic               full_q;
  logic [KEY_W-1:0]   key_q;
  // Keeps in_ready low until the first clock edge after reset release.
  logic               live;

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (in_valid && live) begin
          state_nx = in_last ? FLUSH : GET;
        end
      end
      GET: begin
        if (in_valid) begin
          state_nx = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cam_hit) begin
          state_nx = last_q ? FLUSH : GET;
        end else begin
          state_nx = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_nx = last_q ? FLUSH : GET;
        end
      end
      FLUSH: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    cam_search = 1'b0;
    cam_wr     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = live;
      end
      GET: begin
        in_ready   = 1'b1;
        cam_search = in_valid;
      end
      LOOKUP: begin
      end
      EMIT: begin
        out_valid = 1'b1;
        cam_wr    = out_ready && !full_q;
      end
      FLUSH: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
      end
      default: begin
      end
    endcase

    // prefix only changes on a completed handshake, so the emitted code
    // is stable for as long as the downstream stalls.
    out_code    = out_valid ? prefix : '0;
    cam_wr_code = cam_wr ? next_code[CODE_W-1:0] : '0;

    // Search and write are mutually exclusive by state; with neither
    // strobe active the key parks on its last driven value.
    if (cam_search) begin
      cam_key = {prefix, in_char};
    end else if (cam_wr) begin
      cam_key = {prefix, char_q};
    end else begin
      cam_key = key_q;
    end
  end

  assign dict_full = full_q;

  // ---------------------------------------------------------------
  // Datapath: prefix, latched symbol, code allocator, parked CAM key
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live      <= 1'b0;
      prefix    <= '0;
      char_q    <= '0;
      last_q    <= 1'b0;
      next_code <= FIRST_CODE;
      full_q    <= 1'b0;
      key_q     <= '0;
    end else begin
      live <= 1'b1;

      if (cam_search || cam_wr) begin
        key_q <= cam_key;
      end

      case (state)
        IDLE: begin
          if (clr) begin
            next_code <= FIRST_CODE;
            full_q    <= 1'b0;
          end
          if (in_valid && live) begin
            prefix <= CODE_W'(in_char);
            last_q <= in_last;
          end
        end
        GET: begin
          if (in_valid) begin
            char_q <= in_char;
            last_q <= in_last;
          end
        end
        LOOKUP: begin
          if (cam_hit) begin
            prefix <= cam_code;
          end
        end
        EMIT: begin
          if (out_ready) begin
            prefix <= CODE_W'(char_q);
            if (cam_wr) begin
              next_code <= next_code + 1'b1;
              if (next_code == LAST_CODE) begin
                full_q <= 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzw_dict_ctrl.sv
// tb_lzw_dict_ctrl -- self-checking bench for lzw_dict_ctrl (CODE_W = 9).
//
// A behavioural LZW model (associative-array dictionary) predicts, per
// stream, the emitted codes and CAM inserts; a per-cycle monitor compares
// the DUT against those predictions. A generation-tagged array stands in
// for the external CAM.

module tb_lzw_dict_ctrl;

  localparam int CHAR_W = 8;
  localparam int CODE_W = 9;
  localparam int KEY_W  = CODE_W + CHAR_W;
  localparam int MAXC   = 1 << CODE_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CHAR_W-1:0] in_char;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_last;
  logic [KEY_W-1:0]  cam_key;
  logic              cam_search;
  logic              cam_hit;
  logic [CODE_W-1:0] cam_code;
  logic              cam_wr;
  logic [CODE_W-1:0] cam_wr_code;
  logic              clr;
  logic              dict_full;

  lzw_dict_ctrl #(.CHAR_W(CHAR_W), .CODE_W(CODE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_char     (in_char),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .out_last    (out_last),
    .cam_key     (cam_key),
    .cam_search  (cam_search),
    .cam_hit     (cam_hit),
    .cam_code    (cam_code),
    .cam_wr      (cam_wr),
    .cam_wr_code (cam_wr_code),
    .clr         (clr),
    .dict_full   (dict_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic bail(input string what);
    checks++;
    errors++;
    $display("FAIL timeout %s actual=stuck expected=progress", what);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "bench stopped");
  endtask

  // ---------------- behavioural LZW model ----------------
  int m_dict[int];
  int m_next;
  int exp_code_q[$];
  int exp_last_q[$];
  int exp_wkey_q[$];
  int exp_wcode_q[$];

  task automatic model_reset();
    m_dict.delete();
    m_next = 1 << CHAR_W;
  endtask

  task automatic model_stream(input logic [7:0] syms[$]);
    int w;
    int wc;
    w = int'(syms[0]);
    for (int i = 1; i < syms.size(); i++) begin
      wc = (w << CHAR_W) | int'(syms[i]);
      if (m_dict.exists(wc)) begin
        w = m_dict[wc];
      end else begin
        exp_code_q.push_back(w);
        exp_last_q.push_back(0);
        if (m_next < MAXC) begin
          m_dict[wc] = m_next;
          exp_wkey_q.push_back(wc);
          exp_wcode_q.push_back(m_next);
          m_next++;
        end
        w = int'(syms[i]);
      end
    end
    exp_code_q.push_back(w);
    exp_last_q.push_back(1);
  endtask

  // ---------------- CAM stand-in ----------------
  logic [CODE_W-1:0] cam_code_mem [0:(1<<KEY_W)-1];
  int                cam_gen_mem  [0:(1<<KEY_W)-1];
  int                cam_gen = 1;

  always @(posedge clk) begin
    if (!rst || clr) cam_gen <= cam_gen + 1;
    if (cam_wr) begin
      cam_code_mem[cam_key] <= cam_wr_code;
      cam_gen_mem[cam_key]  <= cam_gen;
    end
    cam_hit  <= cam_search && (cam_gen_mem[cam_key] == cam_gen);
    cam_code <= cam_search ? cam_code_mem[cam_key] : '0;
  end

  // ---------------- downstream ready ----------------
  logic rdy_mode = 1'b0;
  logic rdy_force = 1'b0;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_mode ? rdy_force : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- per-cycle monitor ----------------
  logic              pv_stall = 1'b0;
  logic [CODE_W-1:0] pv_code;
  logic              pv_last;
  int                wr_count = 0;
  int                search_count = 0;

  always @(negedge clk) begin
    if (!rst) begin
      pv_stall <= 1'b0;
    end else begin
      check("search_wr_exclusive", {31'b0, cam_search & cam_wr}, 0);
      if (pv_stall) begin
        check("hold_valid", {31'b0, out_valid}, 1);
        check("hold_code", {23'b0, out_code}, {23'b0, pv_code});
        check("hold_last", {31'b0, out_last}, {31'b0, pv_last});
      end
      if (out_valid && out_ready) begin
        if (exp_code_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected actual=%0h expected=none", out_code);
        end else begin
          check("out_code", {23'b0, out_code}, exp_code_q.pop_front());
          check("out_last", {31'b0, out_last}, exp_last_q.pop_front());
        end
      end
      if (cam_wr) begin
        wr_count++;
        if (exp_wkey_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cam_wr_unexpected actual=%0h expected=none", cam_key);
        end else begin
          check("cam_wr_key", {15'b0, cam_key}, exp_wkey_q.pop_front());
          check("cam_wr_code", {23'b0, cam_wr_code}, exp_wcode_q.pop_front());
        end
      end
      if (cam_search) search_count++;
      pv_stall <= out_valid && !out_ready;
      pv_code  <= out_code;
      pv_last  <= out_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_sym(input logic [7:0] c, input logic last, input logic do_clr);
    int n;
    if ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    clr      = do_clr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 1000);
    if (!in_ready) bail("in_ready");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic prep_stream(input logic [7:0] s[$], input logic do_clr);
    if (do_clr) model_reset();
    model_stream(s);
  endtask

  task automatic play_stream(input logic [7:0] s[$], input logic do_clr);
    int n;
    for (int i = 0; i < s.size(); i++) begin
      send_sym(s[i], i == s.size() - 1, do_clr && i == 0);
    end
    n = 0;
    while ((exp_code_q.size() != 0 || exp_wkey_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (exp_code_q.size() != 0 || exp_wkey_q.size() != 0) bail("drain");
    #1;
    check("dict_full", {31'b0, dict_full}, (m_next >= MAXC) ? 1 : 0);
  endtask

  task automatic run_stream(input logic [7:0] s[$], input logic do_clr);
    prep_stream(s, do_clr);
    play_stream(s, do_clr);
  endtask

  task automatic make_rand(output logic [7:0] s[$], input int len, input int lo, input int hi);
    s = {};
    for (int i = 0; i < len; i++) s.push_back(8'($urandom_range(lo, hi)));
  endtask

  task automatic pin_codes(input string tag, input int lc[$], input int ll[$]);
    check({tag, "_ncodes"}, exp_code_q.size(), lc.size());
    for (int i = 0; i < lc.size() && i < exp_code_q.size(); i++) begin
      check({tag, "_code"}, exp_code_q[i], lc[i]);
      check({tag, "_last"}, exp_last_q[i], ll[i]);
    end
  endtask

  task automatic pin_writes(input string tag, input int lk[$], input int lw[$]);
    check({tag, "_nwrites"}, exp_wkey_q.size(), lk.size());
    for (int i = 0; i < lk.size() && i < exp_wkey_q.size(); i++) begin
      check({tag, "_wkey"}, exp_wkey_q[i], lk[i]);
      check({tag, "_wcode"}, exp_wcode_q[i], lw[i]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 0);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 0);
    check({tag, "_out_code"}, {23'b0, out_code}, 0);
    check({tag, "_out_last"}, {31'b0, out_last}, 0);
    check({tag, "_cam_search"}, {31'b0, cam_search}, 0);
    check({tag, "_cam_wr"}, {31'b0, cam_wr}, 0);
    check({tag, "_cam_key"}, {15'b0, cam_key}, 0);
    check({tag, "_cam_wr_code"}, {23'b0, cam_wr_code}, 0);
    check({tag, "_dict_full"}, {31'b0, dict_full}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] s[$];
    int lc[$];
    int ll[$];
    int lk[$];
    int lw[$];
    int base_wr;
    int base_srch;
    int guard;

    rst = 1'b0;
    in_valid = 1'b0;
    in_char = '0;
    in_last = 1'b0;
    clr = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_release_in_ready", {31'b0, in_ready}, 0);
    @(posedge clk);
    #1;

    // 41 42 41 42(last)
    s = '{8'h41, 8'h42, 8'h41, 8'h42};
    prep_stream(s, 1'b1);
    lc = '{32'h041, 32'h042, 32'h100}; ll = '{0, 0, 1};
    lk = '{32'h4142, 32'h4241};        lw = '{32'h100, 32'h101};
    pin_codes("abab", lc, ll);
    pin_writes("abab", lk, lw);
    play_stream(s, 1'b1);

    // single symbol 5A
    s = '{8'h5A};
    prep_stream(s, 1'b1);
    lc = '{32'h05A}; ll = '{1};
    lk = {};         lw = {};
    pin_codes("single", lc, ll);
    pin_writes("single", lk, lw);
    base_wr = wr_count;
    base_srch = search_count;
    play_stream(s, 1'b1);
    check("single_searches", search_count - base_srch, 0);
    check("single_writes", wr_count - base_wr, 0);

    // 41 41 41 41(last)
    s = '{8'h41, 8'h41, 8'h41, 8'h41};
    prep_stream(s, 1'b1);
    lc = '{32'h041, 32'h100, 32'h041}; ll = '{0, 0, 1};
    lk = '{32'h4141, 32'h10041};       lw = '{32'h100, 32'h101};
    pin_codes("aaaa", lc, ll);
    pin_writes("aaaa", lk, lw);
    play_stream(s, 1'b1);

    // downstream stall in EMIT
    s = '{8'h33, 8'h44, 8'h55};
    prep_stream(s, 1'b1);
    lc = '{32'h033, 32'h044, 32'h055}; ll = '{0, 0, 1};
    lk = '{32'h3344, 32'h4455};        lw = '{32'h100, 32'h101};
    pin_codes("stall", lc, ll);
    pin_writes("stall", lk, lw);
    rdy_force = 1'b0;
    rdy_mode  = 1'b1;
    fork
      play_stream(s, 1'b1);
      begin
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (!(out_valid && !out_last) && guard < 500);
        if (!(out_valid && !out_last)) bail("emit");
        base_wr = wr_count;
        for (int k = 0; k < 5; k++) begin
          check("stall_in_ready", {31'b0, in_ready}, 0);
          check("stall_code", {23'b0, out_code}, 32'h033);
          check("stall_no_wr", {31'b0, cam_wr}, 0);
          @(negedge clk);
        end
        rdy_force = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("stall_single_wr", wr_count - base_wr, 1);
        rdy_mode = 1'b0;
      end
    join

    // random small-alphabet streams: mostly hits
    for (int n = 0; n < 20; n++) begin
      make_rand(s, $urandom_range(1, 25), 8'h41, 8'h44);
      run_stream(s, (n % 7) == 0);
    end

    // fill the dictionary with wide-alphabet streams
    guard = 0;
    while (m_next < MAXC && guard < 100) begin
      make_rand(s, $urandom_range(2, 30), 0, 255);
      run_stream(s, guard == 0);
      guard++;
    end
    check("fill_reached", (m_next >= MAXC) ? 1 : 0, 1);
    for (int n = 0; n < 3; n++) begin
      make_rand(s, $urandom_range(5, 30), 0, 255);
      run_stream(s, 1'b0);
    end
    check("full_sticky", {31'b0, dict_full}, 1);

    // clear from idle: allocation restarts at 100
    s = '{8'h01, 8'h02};
    prep_stream(s, 1'b1);
    lc = '{32'h001, 32'h002}; ll = '{0, 1};
    lk = '{32'h0102};         lw = '{32'h100};
    pin_codes("clr", lc, ll);
    pin_writes("clr", lk, lw);
    play_stream(s, 1'b1);
    check("full_cleared", {31'b0, dict_full}, 0);

    // reset while in LOOKUP
    model_reset();
    send_sym(8'h61, 1'b0, 1'b1);
    send_sym(8'h62, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_release_in_ready", {31'b0, in_ready}, 0);
    model_reset();
    s = '{8'h41, 8'h42};
    prep_stream(s, 1'b0);
    lc = '{32'h041, 32'h042}; ll = '{0, 1};
    lk = '{32'h4142};         lw = '{32'h100};
    pin_codes("post", lc, ll);
    pin_writes("post", lk, lw);
    play_stream(s, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lzw_dict_ctrl.md
LZW_DICT_CTRL -- requirements
Module: lzw_dict_ctrl

Interface
REQ-001 SHALL have parameter CHAR_W, default 8, meaning input symbol width.
REQ-002 SHALL have parameter CODE_W, default 12, meaning dictionary code width; dictionary holds 2^CODE_W codes.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  input symbol valid.
REQ-006 SHALL have port in_ready  output  1  controller accepts symbol this cycle.
REQ-007 SHALL have port in_char  input  CHAR_W  input symbol.
REQ-008 SHALL have port in_last  input  1  symbol is final of stream.
REQ-009 SHALL have port out_valid  output  1  code output valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts code.
REQ-011 SHALL have port out_code  output  CODE_W  emitted code.
REQ-012 SHALL have port out_last  output  1  emitted code is final of stream.
REQ-013 SHALL have port cam_key  output  CODE_W+CHAR_W  {prefix, char} to CAM, used for search and write.
REQ-014 SHALL have port cam_search  output  1  one-cycle search strobe.
REQ-015 SHALL have port cam_hit  input  1  CAM match flag, valid exactly 1 cycle after cam_search.
REQ-016 SHALL have port cam_code  input  CODE_W  matching code, valid with cam_hit.
REQ-017 SHALL have port cam_wr, output 1, one-cycle insert strobe, and port cam_wr_code, output CODE_W, the code assigned to cam_key.
REQ-018 SHALL have port clr  input  1  synchronous dictionary clear, honoured only in IDLE.
REQ-019 SHALL have port dict_full  output  1  all codes allocated.

Function
REQ-020 SHALL implement states IDLE, GET, LOOKUP, EMIT, FLUSH.
REQ-021 IDLE: in_ready=1; accepted symbol loads prefix={0,in_char}; go FLUSH if in_last else GET.
REQ-022 GET: in_ready=1; on accept, latch char and last, drive cam_key={prefix,in_char}, pulse cam_search same cycle, go LOOKUP.
REQ-023 LOOKUP: in_ready=0; cam_hit=1 -> prefix<=cam_code, go FLUSH if latched last else GET; cam_hit=0 -> go EMIT.
REQ-024 EMIT: out_valid=1, out_code=prefix, out_last=0; on out_ready, if !dict_full pulse cam_wr with cam_key={prefix,char}, cam_wr_code=next_code, next_code++; prefix<={0,char}; go FLUSH if latched last else GET.
REQ-025 FLUSH: out_valid=1, out_code=prefix, out_last=1; on out_ready go IDLE.
REQ-026 out_code and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 cam_search and cam_wr SHALL never assert in the same cycle; each is at most one cycle wide.
REQ-028 next_code SHALL start at 2^CHAR_W (256); dict_full SHALL assert when next_code reaches 2^CODE_W and stay set; no write when set.
REQ-029 clr=1 in IDLE SHALL reset next_code to 256 and dict_full to 0 next cycle; clr ignored elsewhere; clr with accepted symbol: clear applied, symbol also accepted.
REQ-030 cam_key SHALL hold its last value when no strobe is active.
REQ-031 Single-symbol stream SHALL emit exactly one code equal to the symbol with out_last=1.
REQ-032 Throughput: hit costs 2 cycles/symbol; miss costs 3 cycles with out_ready=1.

Reset
REQ-033 rst=0 SHALL asynchronously force state IDLE, next_code=256, dict_full=0, prefix=0, in_ready=0 until first edge after release, out_valid=0, out_last=0, out_code=0, cam_search=0, cam_wr=0, cam_key=0, cam_wr_code=0.
REQ-034 rst asserted mid-stream SHALL discard the stream with no further outputs; first post-reset symbol starts a new stream.

Verification
REQ-035 Bytes 41,42,41,42(last), out_ready=1, behavioural CAM -> codes 041,042,100(out_last); writes {041,42}->100, {042,41}->101.
REQ-036 Single byte 5A with in_last -> one code 05A, out_last=1, no cam_search, no cam_wr.
REQ-037 Bytes 41,41,41,41(last) -> codes 041,100,041(last); writes {041,41}->100, {100,41}->101.
REQ-038 out_ready held 0 for 5 cycles in EMIT -> out_code stable, in_ready=0, single cam_wr on release.
REQ-039 CODE_W=9, stream of 300 distinct-pair bytes -> dict_full sets after code 1FF written, no cam_wr afterwards, codes still emitted; clr in IDLE restores next_code=100.
REQ-040 rst pulsed in LOOKUP -> all outputs zero immediately; next stream 41,42(last) -> codes 041,042(last) using write code 100.
